// File: rtl/rv_host_loader_pkg.sv
// Shared constants and FSM state encoding for the host boot loader.
// Frame bytes are little-endian: SYNC, CMD, then command-specific fields.
package rv_host_loader_pkg;

  localparam logic [7:0] LDR_SYNC      = 8'hA5;
  localparam logic [7:0] LDR_CMD_WRITE = 8'h01;
  localparam logic [7:0] LDR_CMD_RUN   = 8'h02;
  localparam logic [7:0] LDR_CMD_HALT  = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_LEN     = 3'd3,
    ST_DATA    = 3'd4,
    ST_WB_REQ  = 3'd5,
    ST_WB_WAIT = 3'd6
  } ldr_state_e;

endpackage

// File: rtl/rv_host_loader.sv
// Boot loader: decodes framed host-link commands and writes words over the
// host-access Wishbone port while holding the CPU in reset.
//
// Handshakes: an rx byte transfers on a cycle with rx_valid_i & rx_ready_o.
// A WB request is accepted on a cycle with ha_stb_o & !ha_stall_i. ha_ack_i
// is honoured on any cycle with ha_cyc_o high, including the accept cycle.
module rv_host_loader
  import rv_host_loader_pkg::*;
#(
  parameter int unsigned g_ack_timeout = 255,
  parameter bit          g_boot_halted = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  output logic        ha_cyc_o,
  output logic        ha_stb_o,
  output logic        ha_we_o,
  output logic [3:0]  ha_sel_o,
  output logic [31:0] ha_adr_o,
  output logic [31:0] ha_dat_o,
  input  logic        ha_ack_i,
  input  logic        ha_stall_i,
  output logic        cpu_rst_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [2:0]  dbg_state_o
);

  localparam logic [7:0] TMO_LAST = 8'(g_ack_timeout - 1);

  ldr_state_e  state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cyc;
  logic        rx_xfer;

  assign cyc     = (state_q == ST_WB_REQ) || (state_q == ST_WB_WAIT);
  assign rx_xfer = rx_valid_i && rx_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      dat_q     <= '0;
      cnt_q     <= '0;
      bcnt_q    <= '0;
      tmo_q     <= '0;
      cpu_rst_q <= g_boot_halted;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      cnt_q     <= cnt_d;
      bcnt_q    <= bcnt_d;
      tmo_q     <= tmo_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    cnt_d     = cnt_q;
    bcnt_d    = bcnt_q;
    tmo_d     = tmo_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_xfer && rx_data_i == LDR_SYNC) state_d = ST_CMD;
      end
      ST_CMD: begin
        if (rx_xfer) begin
          bcnt_d  = 2'd0;
          state_d = ST_IDLE;
          case (rx_data_i)
            LDR_CMD_WRITE: begin
              cpu_rst_d = 1'b1;
              state_d   = ST_ADDR;
            end
            LDR_CMD_RUN: begin
              cpu_rst_d = 1'b0;
              done_d    = 1'b1;
            end
            LDR_CMD_HALT: begin
              cpu_rst_d = 1'b1;
              done_d    = 1'b1;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_ADDR: begin
        if (rx_xfer) begin
          adr_d  = {rx_data_i, adr_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            if (adr_d[1:0] != 2'b00) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_LEN;
            end
          end
        end
      end
      ST_LEN: begin
        if (rx_xfer) begin
          cnt_d  = {rx_data_i, cnt_q[15:8]};
          bcnt_d = bcnt_q[0] ? 2'd0 : 2'd1;
          if (bcnt_q[0]) begin
            if (cnt_d == 16'd0) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
            end
          end
        end
      end
      ST_DATA: begin
        if (rx_xfer) begin
          dat_d  = {rx_data_i, dat_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            tmo_d   = 8'd0;
            state_d = ST_WB_REQ;
          end
        end
      end
      ST_WB_REQ, ST_WB_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        // An ack on the final timeout cycle still completes the write.
        if (ha_ack_i) begin
          adr_d = adr_q + 32'd4;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (state_q == ST_WB_REQ && !ha_stall_i) begin
          state_d = ST_WB_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rx_ready_o  = !cyc;
  assign ha_cyc_o    = cyc;
  assign ha_stb_o    = (state_q == ST_WB_REQ);
  assign ha_we_o     = cyc;
  assign ha_sel_o    = {4{cyc}};
  assign ha_adr_o    = cyc ? adr_q : 32'd0;
  assign ha_dat_o    = cyc ? dat_q : 32'd0;
  assign cpu_rst_o   = cpu_rst_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rv_host_loader.sv
// Bench for rv_host_loader: byte-stream driver, randomized Wishbone slave,
// frame-level reference model with an expected-write queue.
module tb_rv_host_loader;
  import rv_host_loader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic        ha_cyc_o, ha_stb_o, ha_we_o;
  logic [3:0]  ha_sel_o;
  logic [31:0] ha_adr_o, ha_dat_o;
  logic        ha_ack_i, ha_stall_i;
  logic        cpu_rst_o, busy_o, done_o, err_o;
  logic [2:0]  dbg_state_o;

  rv_host_loader #(.g_ack_timeout(255), .g_boot_halted(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .ha_cyc_o(ha_cyc_o), .ha_stb_o(ha_stb_o), .ha_we_o(ha_we_o),
    .ha_sel_o(ha_sel_o), .ha_adr_o(ha_adr_o), .ha_dat_o(ha_dat_o),
    .ha_ack_i(ha_ack_i), .ha_stall_i(ha_stall_i),
    .cpu_rst_o(cpu_rst_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [63:0] exp_q[$];   // {address, data} of each expected WB write
  int          exp_done = 0;
  int          exp_err  = 0;
  logic        exp_rst  = 1'b1;

  int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  int cyc_len = 0, last_cyc_len = 0;

  always @(negedge clk) begin
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    check_eq("done_err_excl", done_o & err_o, 0);
    if (ha_cyc_o) begin
      cyc_len++;
      check_eq("rdy_in_wb", rx_ready_o, 0);
      check_eq("rst_in_wb", cpu_rst_o, 1);
      check_eq("we_sel", {ha_we_o, ha_sel_o}, 5'h1f);
    end else begin
      if (cyc_len > 0) last_cyc_len = cyc_len;
      cyc_len = 0;
      check_eq("stb_wo_cyc", ha_stb_o, 0);
    end
  end

  // ---------------- Wishbone slave ----------------
  int stall_lo = 0, stall_hi = 0, ack_lo = 1, ack_hi = 1;
  bit no_ack = 1'b0;
  int inj_req = 0, inj_seen = 0;

  initial begin
    int ns, na;
    logic [63:0] e;
    ha_stall_i = 1'b0;
    ha_ack_i   = 1'b0;
    forever begin
      @(negedge clk);
      ha_ack_i   = 1'b0;
      ha_stall_i = 1'b0;
      if (inj_req != inj_seen) begin
        inj_seen = inj_req;
        ha_ack_i = 1'b1;
      end else if (ha_cyc_o && ha_stb_o) begin
        ns = $urandom_range(stall_hi, stall_lo);
        ha_stall_i = (ns > 0);
        while (ns > 0) begin
          @(negedge clk);
          check_eq("stb_held", {ha_cyc_o, ha_stb_o}, 2'b11);
          ns--;
          ha_stall_i = (ns > 0);
        end
        acc_cnt++;
        check_eq("wb_write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("wb_adr", ha_adr_o, e[63:32]);
          check_eq("wb_dat", ha_dat_o, e[31:0]);
        end
        na = no_ack ? -1 : $urandom_range(ack_hi, ack_lo);
        if (na == 0) begin
          ha_ack_i = 1'b1;
        end else if (na > 0) begin
          @(negedge clk);
          check_eq("stb_drop", {ha_cyc_o, ha_stb_o}, 2'b10);
          repeat (na - 1) @(negedge clk);
          ha_ack_i = 1'b1;
        end
      end
    end
  end

  // ---------------- byte driver ----------------
  logic [7:0]  frame[$];
  logic [31:0] wq[$];
  int          gap_max = 0;

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    while (!rx_ready_o && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq("rx_accept", t < 1000, 1);
    @(negedge clk);
    if (gap > 0) begin
      rx_valid_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < frame.size(); i++)
      send_byte(frame[i], (i == frame.size() - 1) ? 0 : $urandom_range(gap_max, 0));
    rx_valid_i = 1'b0;
    frame.delete();
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_o && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check_eq("idle_timeout", t < 2000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check_eq({tag, "_done"}, done_cnt, exp_done);
    check_eq({tag, "_err"}, err_cnt, exp_err);
    check_eq({tag, "_cpu_rst"}, cpu_rst_o, exp_rst);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
  endtask

  // ---------------- reference model: frame builders ----------------
  task automatic put32(input logic [31:0] v);
    for (int i = 0; i < 4; i++) frame.push_back(v[8*i +: 8]);
  endtask

  // WRITE of the words in wq to adr; an unaligned address ends the frame early.
  task automatic build_write(input logic [31:0] adr);
    logic [15:0] c;
    frame.push_back(8'hA5);
    frame.push_back(8'h01);
    put32(adr);
    exp_rst = 1'b1;
    if (adr[1:0] != 2'b00) begin
      exp_err++;
      wq.delete();
      return;
    end
    c = 16'(wq.size());
    frame.push_back(c[7:0]);
    frame.push_back(c[15:8]);
    exp_done++;
    for (int k = 0; k < wq.size(); k++) begin
      put32(wq[k]);
      exp_q.push_back({adr + 32'(4 * k), wq[k]});
    end
    wq.delete();
  endtask

  task automatic build_run();
    frame.push_back(8'hA5);
    frame.push_back(8'h02);
    exp_rst = 1'b0;
    exp_done++;
  endtask

  task automatic build_halt();
    frame.push_back(8'hA5);
    frame.push_back(8'h03);
    exp_rst = 1'b1;
    exp_done++;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, kind, acc0;
    logic [31:0] a;
    rst_n_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(negedge clk);

    check_eq("rst_rx_ready", rx_ready_o, 1);
    check_eq("rst_cpu_rst", cpu_rst_o, 1);
    check_eq("rst_cyc_stb", {ha_cyc_o, ha_stb_o, ha_we_o, ha_sel_o}, 0);
    check_eq("rst_adr_dat", {ha_adr_o, ha_dat_o}, 0);
    check_eq("rst_flags", {busy_o, done_o, err_o}, 0);
    check_eq("rst_state", dbg_state_o, ST_IDLE);
    rst_n_i = 1'b1;
    @(negedge clk);

    // 1: RUN releases the CPU
    build_run();
    send_frame();
    wait_idle();
    check_model("t1");
    check_eq("t1_no_wb", acc_cnt, 0);

    // 2: two-word WRITE, zero-wait slave
    stall_lo = 0; stall_hi = 0; ack_lo = 1; ack_hi = 1;
    wq.push_back(32'h44332211);
    wq.push_back(32'h88776655);
    build_write(32'h0000_0100);
    send_frame();
    check_eq("t2_latency", {ha_cyc_o, ha_stb_o}, 2'b11);
    wait_idle();
    check_model("t2");
    check_eq("t2_writes", acc_cnt, 2);

    // 3: stalling, slow slave with rx_valid_i held high
    stall_lo = 3; stall_hi = 3; ack_lo = 5; ack_hi = 5;
    for (int i = 0; i < 3; i++) wq.push_back($urandom);
    build_write({$urandom_range(0, 32'hffff), 2'b00} << 2);
    send_frame();
    wait_idle();
    check_model("t3");

    // 4: frame errors, each followed by a RUN that must work
    stall_lo = 0; stall_hi = 0; ack_lo = 1; ack_hi = 1;
    frame.push_back(8'hA5);
    frame.push_back(8'h07);
    exp_err++;
    send_frame();
    wait_idle();
    check_model("t4_badcmd");
    build_run();
    send_frame();
    wait_idle();
    check_model("t4_run1");
    acc0 = acc_cnt;
    build_write(32'h0000_0102);
    send_frame();
    wait_idle();
    check_model("t4_unaligned");
    check_eq("t4_unaligned_no_wb", acc_cnt, acc0);
    build_run();
    send_frame();
    wait_idle();
    check_model("t4_run2");
    build_halt();
    send_frame();
    wait_idle();
    frame.push_back(8'h00);
    frame.push_back(8'hFF);
    build_run();
    send_frame();
    wait_idle();
    check_model("t4_garbage");

    // 5: slave never acks -> timeout after 255 cycles of cyc
    no_ack = 1'b1;
    wq.push_back($urandom);
    build_write(32'h0000_0200);
    exp_done--;   // aborted by timeout: error instead of done
    exp_err++;
    send_frame();
    wait_idle();
    check_model("t5_timeout");
    check_eq("t5_cyc_len", last_cyc_len, 255);
    inj_req++;
    repeat (4) @(negedge clk);
    check_eq("t5_late_ack_busy", busy_o, 0);
    check_model("t5_late_ack");
    no_ack = 1'b0;
    build_run();
    send_frame();
    wait_idle();
    check_model("t5_run");
    wq.push_back($urandom);
    build_write(32'h0000_0204);
    send_frame();
    wait_idle();
    check_model("t5_write");

    // 6: reset while waiting for ack
    no_ack = 1'b1;
    wq.push_back($urandom);
    wq.push_back($urandom);
    build_write(32'h0000_0300);
    while (frame.size() > 12) void'(frame.pop_back());
    send_frame();
    n = 0;
    while (!(ha_cyc_o && !ha_stb_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_reach_wait", n < 20, 1);
    #2 rst_n_i = 1'b0;
    #1;
    check_eq("t6_cyc_stb", {ha_cyc_o, ha_stb_o}, 0);
    check_eq("t6_cpu_rst", cpu_rst_o, 1);
    check_eq("t6_idle", {busy_o, rx_ready_o}, 2'b01);
    exp_q.delete();
    exp_done--;
    exp_rst = 1'b1;
    no_ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);
    acc0 = acc_cnt;
    build_write(32'h0000_0400);
    send_frame();
    wait_idle();
    check_model("t6_count0");
    check_eq("t6_no_wb", acc_cnt, acc0);

    // 7: randomized frames against the model
    stall_lo = 0; stall_hi = 3; ack_lo = 0; ack_hi = 4; gap_max = 2;
    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(2, 0) == 0) frame.push_back(8'($urandom_range(8'hA4, 0)));
      kind = $urandom_range(9, 0);
      if (kind <= 4) begin
        n = $urandom_range(4, 0);
        for (int k = 0; k < n; k++) wq.push_back($urandom);
        a = $urandom;
        build_write({a[31:2], 2'b00});
      end else if (kind == 5) begin
        build_run();
      end else if (kind == 6) begin
        build_halt();
      end else if (kind == 7) begin
        frame.push_back(8'hA5);
        frame.push_back(8'($urandom_range(255, 4)));
        exp_err++;
      end else if (kind == 8) begin
        a = $urandom;
        build_write({a[31:2], 2'($urandom_range(3, 1))});
      end else begin
        for (int k = 0; k < 3; k++) wq.push_back($urandom);
        build_write(32'hFFFF_FFF8);
      end
      send_frame();
      wait_idle();
      check_model("t7");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
